// File: rtl/gate_op_arbiter_pkg.sv
// Shared types for the gate-op arbiter: opcode and FSM state encodings.
package gate_op_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NAND = 3'd2,
    OP_NOR  = 3'd3,
    OP_XOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/gate_op_arbiter_if.sv
// Request/response bundle between the requesters and the gate-op arbiter.
interface gate_op_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 16
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]                  req_valid;
  logic [NUM_REQ-1:0]                  req_ready;
  logic [NUM_REQ*DATA_W-1:0]           req_a;
  logic [NUM_REQ*DATA_W-1:0]           req_b;
  logic [NUM_REQ*gate_op_pkg::OP_W-1:0] req_op;
  logic                                rsp_valid;
  logic                                rsp_ready;
  logic [ID_W-1:0]                     rsp_id;
  logic [DATA_W-1:0]                   rsp_data;
  logic                                rsp_err;
  logic                                busy;
  logic [CNT_W-1:0]                    op_count;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, op_count
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err, busy, op_count
  );

endinterface

// File: rtl/gate_op_arbiter_nor_gate_unit.sv
// Combinational bitwise gate unit; every function is composed from 2-input NORs.
module nor_gate_unit
  import gate_op_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] y,
  output logic              err
);

  function automatic logic [DATA_W-1:0] nor2(input logic [DATA_W-1:0] x,
                                             input logic [DATA_W-1:0] z);
    return ~(x | z);
  endfunction

  logic [DATA_W-1:0] not_a, not_b, nor_ab, or_ab, and_ab, nand_ab;
  logic [DATA_W-1:0] na_and_b, a_and_nb, xnor_ab, xor_ab;

  assign not_a    = nor2(a, a);
  assign not_b    = nor2(b, b);
  assign nor_ab   = nor2(a, b);
  assign or_ab    = nor2(nor_ab, nor_ab);
  assign and_ab   = nor2(not_a, not_b);
  assign nand_ab  = nor2(and_ab, and_ab);
  // xnor = nor(~a&b, a&~b), both terms reuse nor(a,b)
  assign na_and_b = nor2(a, nor_ab);
  assign a_and_nb = nor2(b, nor_ab);
  assign xnor_ab  = nor2(na_and_b, a_and_nb);
  assign xor_ab   = nor2(xnor_ab, xnor_ab);

  always_comb begin
    y   = '0;
    err = 1'b0;
    unique case (op_e'(op))
      OP_AND:  y = and_ab;
      OP_OR:   y = or_ab;
      OP_NAND: y = nand_ab;
      OP_NOR:  y = nor_ab;
      OP_XOR:  y = xor_ab;
      OP_XNOR: y = xnor_ab;
      OP_NOT:  y = not_a;
      OP_ILL:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// Round-robin arbiter sharing one NOR-built gate unit among NUM_REQ requesters,
// with a registered execute stage and a held response handshake.
module gate_op_arbiter
  import gate_op_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  gate_op_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q, last_grant_d;
  logic [ID_W-1:0]   gid_q, gid_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0]  op_count_q, op_count_d;

  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic [ID_W-1:0]   probe_idx;
  int unsigned       probe;
  logic [DATA_W-1:0] gate_y;
  logic              gate_err;

  nor_gate_unit #(
    .DATA_W(DATA_W)
  ) u_gate (
    .a  (a_q),
    .b  (b_q),
    .op (op_q),
    .y  (gate_y),
    .err(gate_err)
  );

  // First valid requester strictly after last_grant, wrapping.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    probe       = 0;
    probe_idx   = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      probe     = (32'(last_grant_q) + k) % NUM_REQ;
      probe_idx = ID_W'(probe);
      if (!grant_found && bus.req_valid[probe_idx]) begin
        grant_found = 1'b1;
        grant_idx   = probe_idx;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      gid_q        <= '0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= '0;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      op_count_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gid_q        <= gid_d;
      a_q          <= a_d;
      b_q          <= b_d;
      op_q         <= op_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      op_count_q   <= op_count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (grant_found) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    gid_d        = gid_q;
    a_d          = a_q;
    b_d          = b_q;
    op_d         = op_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    op_count_d   = op_count_q;
    unique case (state_q)
      IDLE: begin
        if (grant_found) begin
          a_d          = bus.req_a[grant_idx*DATA_W +: DATA_W];
          b_d          = bus.req_b[grant_idx*DATA_W +: DATA_W];
          op_d         = bus.req_op[grant_idx*OP_W +: OP_W];
          gid_d        = grant_idx;
          last_grant_d = grant_idx;
        end
      end
      EXEC: begin
        rsp_data_d  = gate_y;
        rsp_err_d   = gate_err;
        rsp_id_d    = gid_q;
        rsp_valid_d = 1'b1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          op_count_d  = (&op_count_q) ? op_count_q : op_count_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // The grant is a combinational transfer; masked during reset.
  always_comb begin
    bus.req_ready = '0;
    if (!rst && state_q == IDLE && grant_found) begin
      bus.req_ready = NUM_REQ'(1) << grant_idx;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.op_count  = op_count_q;

endmodule
